vaddr_agu_pipe: RTL and testbench
=================================

VADDR_AGU_PIPE -- requirements
Module: vaddr_agu_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning address/operand width.
REQ-002 The block SHALL have parameter I_IMM, default 12, meaning immediate width.
REQ-003 The block SHALL have parameter IDX_LEN, default 8, meaning load/store-buffer tag width.
REQ-004 The block SHALL have parameter DEPTH, default 2, meaning output-queue entries (power of 2, >=2).
REQ-005 The block SHALL have port clk_i, input, 1 bit, the single clock; all state on rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port flush_i, input, 1 bit, synchronous pipeline flush.
REQ-008 The block SHALL have port vm_mode_i, input, satp_mode_t, translation mode, sampled per request.
REQ-009 The block SHALL have ports valid_i (input, 1) and ready_o (output, 1), the upstream handshake.
REQ-010 The block SHALL have input ports is_store_i (1), rs1_value_i (XLEN), imm_value_i (I_IMM), idx_i (IDX_LEN) and ldst_type_i (ldst_type_t), the request payload.
REQ-011 The block SHALL have ports valid_o (output, 1) and ready_i (input, 1), the downstream handshake.
REQ-012 The block SHALL have output ports is_store_o (1), vaddr_o (XLEN), idx_o (IDX_LEN) and except_o (vadder_except_t), the result payload.

Function
REQ-013 The block SHALL accept a request on a rising edge where valid_i && ready_o && !flush_i, latching all payload fields and vm_mode_i into stage S1.
REQ-014 The block SHALL compute vaddr = rs1 + sign-extended imm, modulo 2^XLEN, from S1, with no carry-out reported.
REQ-015 The block SHALL set the alignment fault when: HALFWORD/HALFWORD_U and vaddr[0]!=0; WORD/WORD_U and vaddr[1:0]!=0; DOUBLEWORD and vaddr[2:0]!=0; BYTE never.
REQ-016 The block SHALL set the page fault when XLEN==64 and: SV39 with vaddr[63:39] != 25 copies of vaddr[38]; SV48 with vaddr[63:48] != 16 copies of vaddr[47]; BARE never.
REQ-017 The block SHALL set except_o to VADDER_ALIGN_EXCEPT if the alignment fault is set, else VADDER_PAGE_EXCEPT if the page fault is set, else VADDER_NO_EXCEPT.
REQ-018 The block SHALL push the S1 result into a DEPTH-entry FIFO when S1 is valid and (count<DEPTH or a pop occurs in the same cycle).
REQ-019 The block SHALL drive ready_o = !S1_valid || S1_drains_this_cycle; this combinational path from ready_i is intentional.
REQ-020 The block SHALL drive valid_o = (count!=0), with all payload outputs taken from the FIFO head; a pop occurs on valid_o && ready_i.
REQ-021 The block SHALL give a latency of exactly 2 cycles from acceptance to valid_o with an empty FIFO, and sustain throughput of 1 request/cycle while ready_i=1.
REQ-022 The block SHALL hold output payload stable while valid_o && !ready_i.
REQ-023 The block SHALL support push and pop in the same cycle when full: count is unchanged, no entry is lost.
REQ-024 The block SHALL wrap FIFO read/write pointers modulo DEPTH, with count of width clog2(DEPTH)+1.
REQ-025 The block SHALL, on flush_i=1, invalidate S1 and empty the FIFO at that edge, ignore valid_i and ready_i in that cycle, and drive valid_o=0 in the next cycle.

Reset
REQ-026 The block SHALL, while rst_i=1, immediately clear S1 valid, count and pointers, and drive valid_o=0, is_store_o=0, vaddr_o=0, idx_o=0, except_o=VADDER_NO_EXCEPT; ready_o=1 after release.
REQ-027 The block SHALL discard any in-flight request on reset mid-operation, never emitting it after release.
REQ-028 The block SHALL reset FIFO storage to zero so that outputs are zero while the FIFO is empty.

Configuration
REQ-029 The block SHALL, with VADDR_AGU_SV57_EN defined, raise a page fault for vm_mode SV57 when XLEN==64 and vaddr[63:57] != 7 copies of vaddr[56].
REQ-030 The block SHALL, without VADDR_AGU_SV57_EN, treat SV57 like BARE (no page fault) and generate no SV57 logic.

Verification
REQ-031 Scenario: rs1=0x1000, imm=0xFF8, DOUBLEWORD, BARE, ready_i=1 -> 2 cycles later valid_o=1, vaddr_o=0x0FF8, NO_EXCEPT.
REQ-032 Scenario: rs1=0x0000_0040_0000_0001, imm=0, WORD, SV39 -> ALIGN_EXCEPT (priority over page fault).
REQ-033 Scenario: rs1=0x0000_0080_0000_0000, imm=0, BYTE -> SV39 gives PAGE_EXCEPT, SV48 gives NO_EXCEPT.
REQ-034 Scenario: DEPTH=2, ready_i=0, 4 back-to-back requests with idx 1..4 -> idx 1,2 queued, idx 3 held in S1, ready_o=0; ready_i=1 -> idx 1,2,3,4 emitted in order on consecutive cycles.
REQ-035 Scenario: flush_i pulsed with FIFO full and S1 valid -> next cycle valid_o=0 and ready_o=1; a new request emerges 2 cycles after acceptance.
REQ-036 Scenario: with VADDR_AGU_SV57_EN, SV57, vaddr=0x0100_0000_0000_0000 -> PAGE_EXCEPT; without the macro -> NO_EXCEPT.

Source files
------------

// File: rtl/vaddr_agu_pipe.sv
// Virtual address generation: S1 operand register, address/fault evaluation, DEPTH-entry result FIFO.
// Define VADDR_AGU_SV57_EN to add the SV57 canonical-address page-fault check.
package vaddr_agu_pkg;
    typedef enum logic [3:0] {
        BARE = 4'd0,
        SV39 = 4'd8,
        SV48 = 4'd9,
        SV57 = 4'd10
    } satp_mode_t;

    typedef enum logic [2:0] {
        BYTE       = 3'd0,
        BYTE_U     = 3'd1,
        HALFWORD   = 3'd2,
        HALFWORD_U = 3'd3,
        WORD       = 3'd4,
        WORD_U     = 3'd5,
        DOUBLEWORD = 3'd6
    } ldst_type_t;

    typedef enum logic [1:0] {
        VADDER_NO_EXCEPT    = 2'd0,
        VADDER_ALIGN_EXCEPT = 2'd1,
        VADDER_PAGE_EXCEPT  = 2'd2
    } vadder_except_t;
endpackage

module vaddr_agu_pipe
    import vaddr_agu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int I_IMM   = 12,
    parameter int IDX_LEN = 8,
    parameter int DEPTH   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  satp_mode_t         vm_mode_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               is_store_i,
    input  logic [XLEN-1:0]    rs1_value_i,
    input  logic [I_IMM-1:0]   imm_value_i,
    input  logic [IDX_LEN-1:0] idx_i,
    input  ldst_type_t         ldst_type_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               is_store_o,
    output logic [XLEN-1:0]    vaddr_o,
    output logic [IDX_LEN-1:0] idx_o,
    output vadder_except_t     except_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_store_q;
    logic [XLEN-1:0]    s1_rs1_q;
    logic [I_IMM-1:0]   s1_imm_q;
    logic [IDX_LEN-1:0] s1_idx_q;
    ldst_type_t         s1_type_q;
    satp_mode_t         s1_mode_q;

    logic [XLEN-1:0]    s1_vaddr;
    logic               align_fault;
    logic               page_fault;
    vadder_except_t     s1_except;

    logic               mem_store_q [DEPTH];
    logic [XLEN-1:0]    mem_vaddr_q [DEPTH];
    logic [IDX_LEN-1:0] mem_idx_q   [DEPTH];
    vadder_except_t     mem_exc_q   [DEPTH];

    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    logic               accept;
    logic               push;
    logic               pop;

    assign valid_o = (count_q != '0);
    assign pop     = valid_o && ready_i && !flush_i;
    // A full FIFO can still take S1 when the head leaves in the same cycle.
    assign push    = s1_valid_q && !flush_i && ((count_q < CNT_W'(DEPTH)) || pop);
    assign ready_o = !s1_valid_q || push;
    assign accept  = valid_i && ready_o && !flush_i;

    assign s1_vaddr = s1_rs1_q + {{(XLEN-I_IMM){s1_imm_q[I_IMM-1]}}, s1_imm_q};

    always_comb begin
        align_fault = 1'b0;
        case (s1_type_q)
            HALFWORD, HALFWORD_U: align_fault = s1_vaddr[0];
            WORD, WORD_U:         align_fault = |s1_vaddr[1:0];
            DOUBLEWORD:           align_fault = |s1_vaddr[2:0];
            default:              align_fault = 1'b0;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_pf64
            logic sv39_bad;
            logic sv48_bad;
            assign sv39_bad = (s1_vaddr[63:39] != {25{s1_vaddr[38]}});
            assign sv48_bad = (s1_vaddr[63:48] != {16{s1_vaddr[47]}});
`ifdef VADDR_AGU_SV57_EN
            logic sv57_bad;
            assign sv57_bad = (s1_vaddr[63:57] != {7{s1_vaddr[56]}});
`endif
            always_comb begin
                page_fault = 1'b0;
                case (s1_mode_q)
                    SV39:    page_fault = sv39_bad;
                    SV48:    page_fault = sv48_bad;
`ifdef VADDR_AGU_SV57_EN
                    SV57:    page_fault = sv57_bad;
`endif
                    default: page_fault = 1'b0;
                endcase
            end
        end else begin : g_pf_none
            assign page_fault = 1'b0;
        end
    endgenerate

    always_comb begin
        if (align_fault) begin
            s1_except = VADDER_ALIGN_EXCEPT;
        end else if (page_fault) begin
            s1_except = VADDER_PAGE_EXCEPT;
        end else begin
            s1_except = VADDER_NO_EXCEPT;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (push) begin
                s1_valid_d = 1'b0;
            end
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_store_q <= 1'b0;
            s1_rs1_q   <= '0;
            s1_imm_q   <= '0;
            s1_idx_q   <= '0;
            s1_type_q  <= BYTE;
            s1_mode_q  <= BARE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (accept) begin
                s1_store_q <= is_store_i;
                s1_rs1_q   <= rs1_value_i;
                s1_imm_q   <= imm_value_i;
                s1_idx_q   <= idx_i;
                s1_type_q  <= ldst_type_i;
                s1_mode_q  <= vm_mode_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_store_q[i] <= 1'b0;
                mem_vaddr_q[i] <= '0;
                mem_idx_q[i]   <= '0;
                mem_exc_q[i]   <= VADDER_NO_EXCEPT;
            end
        end else if (push) begin
            mem_store_q[wr_ptr_q] <= s1_store_q;
            mem_vaddr_q[wr_ptr_q] <= s1_vaddr;
            mem_idx_q[wr_ptr_q]   <= s1_idx_q;
            mem_exc_q[wr_ptr_q]   <= s1_except;
        end
    end

    // Stale entries stay in storage after pop/flush; mask them so an empty queue reads as zero.
    assign is_store_o = valid_o ? mem_store_q[rd_ptr_q] : 1'b0;
    assign vaddr_o    = valid_o ? mem_vaddr_q[rd_ptr_q] : '0;
    assign idx_o      = valid_o ? mem_idx_q[rd_ptr_q]   : '0;
    assign except_o   = valid_o ? mem_exc_q[rd_ptr_q]   : VADDER_NO_EXCEPT;
endmodule

// File: tb/tb_vaddr_agu_pipe.sv
// Bench for vaddr_agu_pipe: transaction-level scoreboard plus directed vectors with literal results.
module tb_vaddr_agu_pipe;
    import vaddr_agu_pkg::*;

    localparam int DEPTH = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    satp_mode_t     vm_mode = BARE;
    logic           valid_i = 1'b0;
    logic           ready_o;
    logic           is_store_i = 1'b0;
    logic [63:0]    rs1_value = '0;
    logic [11:0]    imm_value = '0;
    logic [7:0]     idx_i = '0;
    ldst_type_t     ldst_type = BYTE;
    logic           valid_o;
    logic           ready_i = 1'b0;
    logic           is_store_o;
    logic [63:0]    vaddr_o;
    logic [7:0]     idx_o;
    vadder_except_t except_o;

    int n_cmp = 0;
    int n_bad = 0;

    vaddr_agu_pipe #(.XLEN(64), .I_IMM(12), .IDX_LEN(8), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .vm_mode_i(vm_mode),
        .valid_i(valid_i), .ready_o(ready_o),
        .is_store_i(is_store_i), .rs1_value_i(rs1_value), .imm_value_i(imm_value),
        .idx_i(idx_i), .ldst_type_i(ldst_type),
        .valid_o(valid_o), .ready_i(ready_i),
        .is_store_o(is_store_o), .vaddr_o(vaddr_o), .idx_o(idx_o), .except_o(except_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: full-width add, alignment by access size, canonical range as signed interval.
    function automatic void exp_calc(input logic [63:0] rs1, input logic [11:0] imm,
                                     input ldst_type_t t, input satp_mode_t m,
                                     output logic [63:0] va, output vadder_except_t ex);
        longint sv;
        longint lim;
        int     sz;
        bit     al;
        bit     pf;
        va = rs1 + 64'(longint'($signed(imm)));
        case (t)
            HALFWORD, HALFWORD_U: sz = 2;
            WORD, WORD_U:         sz = 4;
            DOUBLEWORD:           sz = 8;
            default:              sz = 1;
        endcase
        al  = (va % 64'(sz)) != 64'd0;
        sv  = longint'(va);
        pf  = 1'b0;
        lim = 0;
        if (m == SV39) lim = longint'(1) << 38;
        if (m == SV48) lim = longint'(1) << 47;
`ifdef VADDR_AGU_SV57_EN
        if (m == SV57) lim = longint'(1) << 56;
`endif
        if (lim != 0) pf = !(sv >= -lim && sv < lim);
        ex = al ? VADDER_ALIGN_EXCEPT : (pf ? VADDER_PAGE_EXCEPT : VADDER_NO_EXCEPT);
    endfunction

    typedef struct {
        logic           st;
        logic [63:0]    va;
        logic [7:0]     idx;
        vadder_except_t ex;
        int             acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_in;
    bit   exp_valid;
    bit   s1v;
    bit   exp_ready;

    // Each in-flight request becomes visible two cycles after acceptance, oldest first.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            check("rst_valid_o", valid_o, 0);
            check("rst_vaddr_o", vaddr_o, 0);
            check("rst_idx_o", idx_o, 0);
            check("rst_is_store_o", is_store_o, 0);
            check("rst_except_o", except_o, VADDER_NO_EXCEPT);
        end else begin
            exp_valid = (sb.size() > 0) && (cyc - sb[0].acc >= 2);
            check("valid_o", valid_o, exp_valid);
            if (exp_valid) begin
                check("vaddr_o", vaddr_o, sb[0].va);
                check("idx_o", idx_o, sb[0].idx);
                check("is_store_o", is_store_o, sb[0].st);
                check("except_o", except_o, sb[0].ex);
            end else begin
                check("empty_vaddr_o", vaddr_o, 0);
                check("empty_idx_o", idx_o, 0);
            end
            if (flush) begin
                sb.delete();
            end else begin
                n_in = sb.size();
                s1v = (n_in > 0) && ((sb[n_in-1].acc == cyc - 1) || (n_in > DEPTH));
                exp_ready = !s1v || ((n_in - int'(s1v)) < DEPTH) || (exp_valid && ready_i);
                check("ready_o", ready_o, exp_ready);
                if (exp_valid && ready_i) void'(sb.pop_front());
                if (valid_i && ready_o) begin
                    exp_calc(rs1_value, imm_value, ldst_type, vm_mode, e.va, e.ex);
                    e.st  = is_store_i;
                    e.idx = idx_i;
                    e.acc = cyc;
                    sb.push_back(e);
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [63:0] rs1, input logic [11:0] imm,
                         input logic [7:0] idx, input ldst_type_t t, input satp_mode_t m);
        valid_i    = 1'b1;
        is_store_i = st;
        rs1_value  = rs1;
        imm_value  = imm;
        idx_i      = idx;
        ldst_type  = t;
        vm_mode    = m;
    endtask

`ifdef VADDR_AGU_SV57_EN
    localparam vadder_except_t SV57_EXP = VADDER_PAGE_EXCEPT;
`else
    localparam vadder_except_t SV57_EXP = VADDER_NO_EXCEPT;
`endif

    logic [63:0]    dv_rs1 [8] = '{64'h1000, 64'h0000_0040_0000_0001, 64'h0000_0080_0000_0000,
                                   64'h0000_0080_0000_0000, 64'h0100_0000_0000_0000, 64'h2001,
                                   64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_8000_0000_0000};
    logic [11:0]    dv_imm [8] = '{12'hFF8, 12'h000, 12'h000, 12'h000, 12'h000, 12'h002, 12'h001, 12'h7FF};
    ldst_type_t     dv_typ [8] = '{DOUBLEWORD, WORD, BYTE, BYTE, BYTE, HALFWORD_U, WORD, BYTE};
    satp_mode_t     dv_mod [8] = '{BARE, SV39, SV39, SV48, SV57, BARE, BARE, SV48};
    logic [63:0]    dv_va  [8] = '{64'h0FF8, 64'h0000_0040_0000_0001, 64'h0000_0080_0000_0000,
                                   64'h0000_0080_0000_0000, 64'h0100_0000_0000_0000, 64'h2003,
                                   64'h0, 64'h0000_8000_0000_07FF};
    vadder_except_t dv_ex  [8] = '{VADDER_NO_EXCEPT, VADDER_ALIGN_EXCEPT, VADDER_PAGE_EXCEPT,
                                   VADDER_NO_EXCEPT, SV57_EXP, VADDER_ALIGN_EXCEPT,
                                   VADDER_NO_EXCEPT, VADDER_PAGE_EXCEPT};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", ready_o, 1);
        tick();

        // Directed vectors, back-to-back with ready_i high: result k appears in cycle k+2.
        ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(i[0], dv_rs1[i], dv_imm[i], 8'(8'h31 + i), dv_typ[i], dv_mod[i]);
            else valid_i = 1'b0;
            @(negedge clk);
            if (i == 1) check("latency_not_early", valid_o, 0);
            if (i >= 2) begin
                check("dv_valid", valid_o, 1);
                check("dv_idx", idx_o, 8'(8'h31 + i - 2));
                check("dv_vaddr", vaddr_o, dv_va[i-2]);
                check("dv_except", except_o, dv_ex[i-2]);
            end
            tick();
        end

        // Backpressure: two entries queue, the third waits in S1, the fourth is refused.
        ready_i = 1'b0;
        drive(0, 64'h100, 12'h0, 8'd1, BYTE, BARE); tick();
        drive(0, 64'h200, 12'h0, 8'd2, BYTE, BARE); tick();
        drive(0, 64'h300, 12'h0, 8'd3, BYTE, BARE); tick();
        drive(0, 64'h400, 12'h0, 8'd4, BYTE, BARE);
        @(negedge clk);
        check("bp_ready_low", ready_o, 0);
        check("bp_head_idx", idx_o, 1);
        tick();
        @(negedge clk);
        check("bp_ready_still_low", ready_o, 0);
        check("bp_hold_idx", idx_o, 1);
        check("bp_hold_vaddr", vaddr_o, 64'h100);
        tick();
        ready_i = 1'b1;
        @(negedge clk);
        check("bp_ready_release", ready_o, 1);
        check("bp_out1", idx_o, 1);
        tick();
        valid_i = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check("bp_order", idx_o, k);
            tick();
        end
        @(negedge clk);
        check("bp_drained", valid_o, 0);
        tick();

        // Flush with the queue full and S1 occupied.
        ready_i = 1'b0;
        drive(1, 64'h5100, 12'h0, 8'h51, WORD, BARE); tick();
        drive(1, 64'h5200, 12'h0, 8'h52, WORD, BARE); tick();
        drive(1, 64'h5300, 12'h0, 8'h53, WORD, BARE); tick();
        drive(1, 64'h5400, 12'h0, 8'h54, WORD, BARE);
        flush   = 1'b1;
        ready_i = 1'b1;
        tick();
        flush = 1'b0;
        drive(0, 64'h6000, 12'h010, 8'h60, DOUBLEWORD, SV39);
        @(negedge clk);
        check("flush_valid_low", valid_o, 0);
        check("flush_ready_high", ready_o, 1);
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        check("post_flush_not_early", valid_o, 0);
        tick();
        @(negedge clk);
        check("post_flush_valid", valid_o, 1);
        check("post_flush_idx", idx_o, 8'h60);
        check("post_flush_vaddr", vaddr_o, 64'h6010);
        tick();

        // Mixed traffic with intermittent valid/ready; checked by the scoreboard.
        for (int i = 0; i < 30; i++) begin
            ready_i = ((i % 4) != 3) && ((i % 7) != 5);
            if ((i % 5) != 4)
                drive(i[1], (64'(i) << (30 + (i % 20))) + 64'(i * 3), 12'(i * 157),
                      8'(8'h80 + i), ldst_type_t'(3'(i % 7)), satp_mode_t'((i % 3 == 0) ? BARE :
                      ((i % 3 == 1) ? SV39 : SV48)));
            else
                valid_i = 1'b0;
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (5) tick();

        // Reset with requests in flight: nothing may come out afterwards.
        ready_i = 1'b0;
        drive(0, 64'h7000, 12'h0, 8'h70, BYTE, BARE); tick();
        drive(0, 64'h7100, 12'h0, 8'h71, BYTE, BARE); tick();
        valid_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_reset_no_output", valid_o, 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
